// File: rtl/pkt_rr_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_rr_mux_pkg
//  Description : Shared definitions for the packet round-robin multiplexer:
//                FSM state encoding, id-width helper and dbg_sig field map.
//  Revision    : 1.0  initial release
// ============================================================================
package pkt_rr_mux_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  // dbg_sig field layout
  localparam int DBG_PKT_LSB   = 16;  // [31:16] pkt_cnt
  localparam int DBG_ERR_LSB   = 8;   // [15:8]  sop_err_cnt
  localparam int DBG_STATE_BIT = 7;   // [7]     1 = XFER
  localparam int DBG_SEL_LSB   = 0;   // [3:0]   sel_id, zero-extended

  // Number of bits needed to encode values 0..value-1.
  function automatic int clogb2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : pkt_rr_mux_pkg
`default_nettype wire

// File: rtl/pkt_rr_mux_if.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_rr_mux_if
//  Description : Bundles the per-channel input streams and the merged output
//                stream of pkt_rr_mux.
//                slave  : view of the multiplexer (consumes in_*, drives out_*)
//                master : view of the environment (drives in_*, consumes out_*)
//  Revision    : 1.0  initial release
// ============================================================================
interface pkt_rr_mux_if #(
  parameter int REQ_NUM  = 4,
  parameter int DATA_WID = 64,
  parameter int ID_WID   = 2
);
  logic [REQ_NUM-1:0]          in_vld;
  logic [REQ_NUM-1:0]          in_sop;
  logic [REQ_NUM-1:0]          in_eop;
  logic [REQ_NUM*DATA_WID-1:0] in_data;   // channel k at [k*DATA_WID +: DATA_WID]
  logic [REQ_NUM-1:0]          in_rdy;
  logic                        out_vld;
  logic                        out_sop;
  logic                        out_eop;
  logic [DATA_WID-1:0]         out_data;
  logic [ID_WID-1:0]           out_id;
  logic                        out_rdy;

  modport slave (
    input  in_vld, in_sop, in_eop, in_data, out_rdy,
    output in_rdy, out_vld, out_sop, out_eop, out_data, out_id
  );

  modport master (
    output in_vld, in_sop, in_eop, in_data, out_rdy,
    input  in_rdy, out_vld, out_sop, out_eop, out_data, out_id
  );
endinterface : pkt_rr_mux_if
`default_nettype wire

// File: rtl/pkt_rr_mux_pick.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_rr_pick
//  Description : Combinational rotate-priority picker. Searches req starting
//                at last_id+1 and wrapping modulo REQ_NUM; the channel that
//                won last is therefore the lowest priority.
//  Ports       : req_i      per-channel request
//                last_id_i  channel granted most recently
//                win_id_o   selected channel (0 when no request)
//                any_req_o  at least one request present
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_rr_pick #(
  parameter int REQ_NUM = 4,
  parameter int ID_WID  = 2
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [ID_WID-1:0]  last_id_i,
  output logic [ID_WID-1:0]  win_id_o,
  output logic               any_req_o
);

  logic found;
  int   idx;

  always_comb begin
    win_id_o = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= REQ_NUM; k++) begin
      // explicit wrap keeps non-power-of-two REQ_NUM correct
      idx = int'(last_id_i) + k;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      if (!found && req_i[idx]) begin
        found    = 1'b1;
        win_id_o = ID_WID'(idx);
      end
    end
  end

  assign any_req_o = |req_i;

endmodule : pkt_rr_pick
`default_nettype wire

// File: rtl/pkt_rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : pkt_rr_mux
//  Description : Packet-level N:1 stream multiplexer. Round-robin arbitration
//                with packet locking (sop..eop forwarded before re-arbitrating),
//                one registered output stage tagged with the source channel.
//  Ports       : clk        rising-edge clock
//                rst_n      asynchronous active-low reset
//                bus        stream bundle (slave view): in_vld/sop/eop/data,
//                           in_rdy, out_vld/sop/eop/data/id, out_rdy
//                dbg_sig_o  {pkt_cnt, sop_err_cnt, state, 3'b0, sel_id}
//  Revision    : 1.0  initial release
// ============================================================================
module pkt_rr_mux
  import pkt_rr_mux_pkg::*;
#(
  parameter int REQ_NUM  = 4,
  parameter int DATA_WID = 64,
  parameter int ID_WID   = clogb2(REQ_NUM),
  parameter int DBG_WID  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  pkt_rr_mux_if.slave        bus,
  output logic [DBG_WID-1:0] dbg_sig_o
);

  state_e              state_q, state_d;
  logic [ID_WID-1:0]   sel_id_q, sel_id_d;
  logic [ID_WID-1:0]   last_id_q, last_id_d;
  logic                first_q;        // next accepted beat is the packet's first
  logic                out_vld_q, out_sop_q, out_eop_q;
  logic [DATA_WID-1:0] out_data_q;
  logic [ID_WID-1:0]   out_id_q;
  logic [15:0]         pkt_cnt_q;
  logic [7:0]          sop_err_cnt_q;

  logic [REQ_NUM-1:0]  w_in_rdy;
  logic                w_acc;
  logic                w_sel_sop, w_sel_eop;
  logic [DATA_WID-1:0] w_sel_data;
  logic [ID_WID-1:0]   w_win_id;
  logic                w_any_req;

  pkt_rr_pick #(
    .REQ_NUM (REQ_NUM),
    .ID_WID  (ID_WID)
  ) u_pick (
    .req_i     (bus.in_vld),
    .last_id_i (last_id_q),
    .win_id_o  (w_win_id),
    .any_req_o (w_any_req)
  );

  assign w_sel_sop  = bus.in_sop[sel_id_q];
  assign w_sel_eop  = bus.in_eop[sel_id_q];
  assign w_sel_data = bus.in_data[int'(sel_id_q)*DATA_WID +: DATA_WID];

  // ---- FSM: state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_id_q  <= '0;
      last_id_q <= ID_WID'(REQ_NUM - 1);
    end else begin
      state_q   <= state_d;
      sel_id_q  <= sel_id_d;
      last_id_q <= last_id_d;
    end
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d   = state_q;
    sel_id_d  = sel_id_q;
    last_id_d = last_id_q;
    case (state_q)
      ST_IDLE: begin
        if (w_any_req) begin
          sel_id_d = w_win_id;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        // requests arriving with the eop are seen in the following IDLE cycle
        if (w_acc && w_sel_eop) begin
          last_id_d = sel_id_q;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    w_in_rdy = '0;
    if (state_q == ST_XFER) begin
      // accept when the output register is empty or being drained this cycle
      w_in_rdy[sel_id_q] = !out_vld_q || bus.out_rdy;
    end
    w_acc = bus.in_vld[sel_id_q] && w_in_rdy[sel_id_q];
  end

  // ---- output register, packet framing and counters ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q     <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_data_q    <= '0;
      out_id_q      <= '0;
      first_q       <= 1'b1;
      pkt_cnt_q     <= '0;
      sop_err_cnt_q <= '0;
    end else begin
      if (w_acc) begin
        out_vld_q  <= 1'b1;
        out_sop_q  <= w_sel_sop;
        out_eop_q  <= w_sel_eop;
        out_data_q <= w_sel_data;
        out_id_q   <= sel_id_q;
      end else if (bus.out_rdy) begin
        out_vld_q  <= 1'b0;
      end

      if (state_q == ST_IDLE) first_q <= 1'b1;
      else if (w_acc)         first_q <= 1'b0;

      if (w_acc && w_sel_eop) pkt_cnt_q <= pkt_cnt_q + 16'd1;

      // sop must appear on the first beat and only there; beats still pass
      if (w_acc && (first_q != w_sel_sop) && (sop_err_cnt_q != 8'hFF))
        sop_err_cnt_q <= sop_err_cnt_q + 8'd1;
    end
  end

  assign bus.in_rdy   = w_in_rdy;
  assign bus.out_vld  = out_vld_q;
  assign bus.out_sop  = out_sop_q;
  assign bus.out_eop  = out_eop_q;
  assign bus.out_data = out_data_q;
  assign bus.out_id   = out_id_q;

  always_comb begin
    dbg_sig_o                        = '0;
    dbg_sig_o[DBG_PKT_LSB +: 16]     = pkt_cnt_q;
    dbg_sig_o[DBG_ERR_LSB +: 8]      = sop_err_cnt_q;
    dbg_sig_o[DBG_STATE_BIT]         = (state_q == ST_XFER);
    dbg_sig_o[DBG_SEL_LSB +: 4]      = 4'(sel_id_q);
  end

endmodule : pkt_rr_mux
`default_nettype wire
